uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 36 +++
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: word output, valid/ready, error pulses.
// rx_parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int Word_len = 8
);
    logic [Word_len-1:0] rx_data;
    logic                rx_data_valid;
    logic                rx_data_ready;
    logic                rx_frame_err;
    logic                rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic                rx_parity_err;
`endif

    modport master (
        output rx_data,
        output rx_data_valid,
        input  rx_data_ready,
        output rx_frame_err,
`ifdef UART_RX_PARITY_EN
        output rx_parity_err,
`endif
        output rx_overrun
    );

    modport slave (
        input  rx_data,
        input  rx_data_valid,
        output rx_data_ready,
        input  rx_frame_err,
`ifdef UART_RX_PARITY_EN
        input  rx_parity_err,
`endif
        input  rx_overrun
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, valid/ready output with overrun.
// Optional even-parity bit check enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int clk_rate = 100000000,
    parameter int Baud     = 115200,
    parameter int Word_len = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     Uart_rx,
    uart_rx_if.master bus
);
    localparam int Baud_div = clk_rate / Baud;
    localparam int Half     = Baud_div / 2;
    localparam int CNT_W    = (Baud_div > 1) ? $clog2(Baud_div) : 1;
    localparam int BIT_W    = $clog2(Word_len + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Baud_div - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(Half - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(Word_len - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif

    logic                rx_meta;
    logic                rx_s;
    logic [2:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [Word_len-1:0] shift;

    logic [Word_len-1:0] data_r;
    logic                valid_r;
    logic                frame_err_r;
    logic                overrun_r;

    logic                at_last;
    logic                deliver_now;
    logic                frame_err_now;
`ifdef UART_RX_PARITY_EN
    logic                parity_bad;
    logic                parity_err_now;
    logic                parity_err_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= Uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign at_last = (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    // Even parity: data plus parity bit must carry an even number of ones.
    assign parity_err_now = (state == PARITY) && at_last && (^{shift, rx_s});
    assign deliver_now    = (state == STOP) && at_last && rx_s && !parity_bad;
`else
    assign deliver_now    = (state == STOP) && at_last && rx_s;
`endif
    assign frame_err_now  = (state == STOP) && at_last && !rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BREAK;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                    parity_bad <= 1'b0;
`endif
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    // Recheck at mid start bit; a high line here was a glitch.
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (at_last) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[Word_len-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_last) begin
                        cnt        <= '0;
                        parity_bad <= ^{shift, rx_s};
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (at_last) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Stay deaf until the line returns high.
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: begin
                    state <= BREAK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_r      <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            frame_err_r <= frame_err_now;
            overrun_r   <= deliver_now && valid_r && !bus.rx_data_ready;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= parity_err_now;
`endif
            // Sampling never stalls; a word arriving to an occupied output is dropped.
            if (deliver_now && (!valid_r || bus.rx_data_ready)) begin
                data_r  <= shift;
                valid_r <= 1'b1;
            end else if (valid_r && bus.rx_data_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = data_r;
    assign bus.rx_data_valid = valid_r;
    assign bus.rx_frame_err  = frame_err_r;
    assign bus.rx_overrun    = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign bus.rx_parity_err = parity_err_r;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at Baud_div=16 (1.6 MHz clock, 100 kbaud).
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line = 1'b1;

    int checks = 0;
    int passes = 0;

    int n_acc = 0;
    int n_vld = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_perr = 0;
    logic [7:0] last_data = 8'h00;

    int b_acc, b_vld, b_ferr, b_ovr, b_perr;

    uart_rx_if #(.Word_len(8)) bus ();

    uart_rx #(
        .clk_rate(1600000),
        .Baud    (100000),
        .Word_len(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Uart_rx(line),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rx_data_valid && bus.rx_data_ready) begin
            n_acc     <= n_acc + 1;
            last_data <= bus.rx_data;
        end
        if (bus.rx_data_valid) n_vld <= n_vld + 1;
        if (bus.rx_frame_err)  n_ferr <= n_ferr + 1;
        if (bus.rx_overrun)    n_ovr <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
        if (bus.rx_parity_err) n_perr <= n_perr + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_acc = n_acc; b_vld = n_vld; b_ferr = n_ferr; b_ovr = n_ovr; b_perr = n_perr;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        line = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            wait_cyc(16);
        end
`ifdef UART_RX_PARITY_EN
        line = ^d;
        wait_cyc(16);
`endif
        line = stop;
        wait_cyc(16);
        line = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic p);
        line = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            wait_cyc(16);
        end
        line = p;
        wait_cyc(16);
        line = 1'b1;
        wait_cyc(16);
    endtask
`endif

    initial begin
        bus.rx_data_ready = 1'b1;
        wait_cyc(5);
        check("reset_data",  32'(bus.rx_data), 32'h0);
        check("reset_valid", 32'(bus.rx_data_valid), 32'h0);
        check("reset_ferr",  32'(bus.rx_frame_err), 32'h0);
        check("reset_ovr",   32'(bus.rx_overrun), 32'h0);
        rst = 1'b0;
        wait_cyc(10);

        // Plain frame, consumer ready
        snap();
        send_frame(8'hA5, 1'b1);
        wait_cyc(30);
        check("a5_data",  32'(last_data), 32'hA5);
        check("a5_acc",   32'(n_acc - b_acc), 32'd1);
        check("a5_vlen",  32'(n_vld - b_vld), 32'd1);
        check("a5_ferr",  32'(n_ferr - b_ferr), 32'd0);
        check("a5_ovr",   32'(n_ovr - b_ovr), 32'd0);

        // Back-pressure: second word overruns
        bus.rx_data_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1);
        wait_cyc(30);
        send_frame(8'h7E, 1'b1);
        wait_cyc(30);
        check("bp_valid", 32'(bus.rx_data_valid), 32'd1);
        check("bp_data",  32'(bus.rx_data), 32'h3C);
        check("bp_ovr",   32'(n_ovr - b_ovr), 32'd1);
        check("bp_acc",   32'(n_acc - b_acc), 32'd0);
        bus.rx_data_ready = 1'b1;
        wait_cyc(1);
        check("bp_drop",  32'(bus.rx_data_valid), 32'd0);
        check("bp_acc2",  32'(n_acc - b_acc), 32'd1);
        check("bp_ldata", 32'(last_data), 32'h3C);

        // Framing error followed by a long break
        snap();
        send_frame(8'h55, 1'b0);
        line = 1'b0;
        wait_cyc(640);
        check("fe_ferr", 32'(n_ferr - b_ferr), 32'd1);
        check("fe_vld",  32'(n_vld - b_vld), 32'd0);
        check("fe_ovr",  32'(n_ovr - b_ovr), 32'd0);
        line = 1'b1;
        wait_cyc(20);
        send_frame(8'h01, 1'b1);
        wait_cyc(30);
        check("fe_next", 32'(last_data), 32'h01);
        check("fe_ferr2", 32'(n_ferr - b_ferr), 32'd1);

        // Short glitch on idle line is rejected
        snap();
        line = 1'b0;
        wait_cyc(3);
        line = 1'b1;
        wait_cyc(40);
        check("gl_vld",  32'(n_vld - b_vld), 32'd0);
        check("gl_ferr", 32'(n_ferr - b_ferr), 32'd0);
        send_frame(8'hFF, 1'b1);
        wait_cyc(30);
        check("gl_next", 32'(last_data), 32'hFF);
        check("gl_acc",  32'(n_acc - b_acc), 32'd1);

        // Reset in the middle of the data bits of 0x81
        snap();
        line = 1'b0;
        wait_cyc(16);
        line = 1'b1; wait_cyc(16);
        line = 1'b0; wait_cyc(16);
        line = 1'b0; wait_cyc(8);
        rst = 1'b1;
        line = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(200);
        check("rs_vld",  32'(n_vld - b_vld), 32'd0);
        check("rs_ferr", 32'(n_ferr - b_ferr), 32'd0);
        check("rs_ovr",  32'(n_ovr - b_ovr), 32'd0);
        send_frame(8'h18, 1'b1);
        wait_cyc(30);
        check("rs_next", 32'(last_data), 32'h18);
        check("rs_acc",  32'(n_acc - b_acc), 32'd1);

`ifdef UART_RX_PARITY_EN
        snap();
        send_par(8'h07, 1'b1);
        wait_cyc(30);
        check("par_ok_data", 32'(last_data), 32'h07);
        check("par_ok_perr", 32'(n_perr - b_perr), 32'd0);
        snap();
        send_par(8'h07, 1'b0);
        wait_cyc(30);
        check("par_bad_perr", 32'(n_perr - b_perr), 32'd1);
        check("par_bad_vld",  32'(n_vld - b_vld), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
